// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit datapath: one state per cycle through
// fetch/decode/execute/memory/writeback, with HALT and illegal-opcode handling.
module multicycle_ctrl #(
    parameter logic [3:0] ALU_ADD   = 4'b0000,
    parameter logic [3:0] ALU_SUB   = 4'b0001,
    parameter logic [3:0] ALU_PASSA = 4'b1111
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] OPCODE,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic [1:0] BranchCond,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUSrcA,
    output logic       RegRead,
    output logic       RegWrite,
    output logic [1:0] SZS,
    output logic [1:0] RegDst,
    output logic       Halted,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_R_EXEC   = 4'h2,
        S_R_WB     = 4'h3,
        S_I_EXEC   = 4'h4,
        S_I_WB     = 4'h5,
        S_MEM_ADDR = 4'h6,
        S_MEM_RD   = 4'h7,
        S_MEM_WB   = 4'h8,
        S_MEM_WR   = 4'h9,
        S_BRANCH   = 4'hA,
        S_JUMP     = 4'hB,
        S_JAL_LINK = 4'hC,
        S_JAL_WB   = 4'hD,
        S_ILLEGAL  = 4'hE,
        S_HALT     = 4'hF
    } state_t;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       mdr_write;
        logic [1:0] branch_cond;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic [1:0] alu_src_b;
        logic [2:0] alu_src_a;
        logic       reg_write;
        logic [1:0] szs;
        logic [1:0] reg_dst;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    // Control word for a state; opcode-dependent fields sample OPCODE while
    // leaving DECODE, when the instruction register is already stable.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_a = 3'b000;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
                c.pc_source = 2'b00;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 3'b000;
                c.alu_src_b = 2'b10;
                c.szs       = 2'b00;
                c.alu_op    = ALU_ADD;
            end
            S_R_EXEC: begin
                c.alu_src_a = 3'b001;
                c.alu_src_b = 2'b00;
                c.alu_op    = op[3:0];
            end
            S_R_WB: begin
                c.reg_dst   = 2'b01;
                c.reg_write = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 3'b100;
                c.alu_src_b = 2'b10;
                c.alu_op    = op[3:0];
                c.szs       = {1'b0, op[3]};
            end
            S_I_WB: begin
                c.reg_dst   = 2'b00;
                c.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
                c.alu_src_a = 3'b100;
                c.alu_src_b = 2'b10;
                c.szs       = 2'b00;
                c.alu_op    = ALU_ADD;
                c.mdr_write = (s == S_MEM_RD);
                c.mem_write = (s == S_MEM_WR);
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_dst    = 2'b00;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 3'b001;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_SUB;
                c.branch_cond   = {1'b0, op[0]};
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_JAL_LINK: begin
                c.alu_src_a = 3'b000;
                c.alu_op    = ALU_PASSA;
            end
            S_JAL_WB: begin
                c.reg_dst   = 2'b10;
                c.reg_write = 1'b1;
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_ILLEGAL: c.illegal_op = 1'b1;
            S_HALT:    c.halted     = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_o;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (OPCODE[5:4] == 2'b00)      state_d = S_R_EXEC;
                else if (OPCODE[5:4] == 2'b01) state_d = S_I_EXEC;
                else begin
                    case (OPCODE)
                        6'h20, 6'h21: state_d = S_MEM_ADDR;
                        6'h22, 6'h23: state_d = S_BRANCH;
                        6'h24:        state_d = S_JUMP;
                        6'h25:        state_d = S_JAL_LINK;
                        6'h3F:        state_d = S_HALT;
                        default:      state_d = S_ILLEGAL;
                    endcase
                end
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (OPCODE == 6'h20) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_JAL_LINK: state_d = S_JAL_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so it is glitch-free;
    // its reset value is the FETCH word so fetch runs in the first cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH, 6'h00);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, OPCODE);
        end
    end

    assign ctrl_o = Reset ? ctrl_q : '0;

    assign PCWriteCond = ctrl_o.pc_write_cond;
    assign PCWrite     = ctrl_o.pc_write;
    assign MemWrite    = ctrl_o.mem_write;
    assign MemtoReg    = ctrl_o.mem_to_reg;
    assign IRWrite     = ctrl_o.ir_write;
    assign MDRWrite    = ctrl_o.mdr_write;
    assign BranchCond  = ctrl_o.branch_cond;
    assign PCSource    = ctrl_o.pc_source;
    assign ALUOp       = ctrl_o.alu_op;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign RegRead     = 1'b0;
    assign RegWrite    = ctrl_o.reg_write;
    assign SZS         = ctrl_o.szs;
    assign RegDst      = ctrl_o.reg_dst;
    assign Halted      = ctrl_o.halted;
    assign IllegalOp   = ctrl_o.illegal_op;
    assign State       = Reset ? state_q : 4'h0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle tables model the expected
// control word; one negedge process compares every checked cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pwc, pw, mw, m2r, irw, mdrw;
        logic [1:0] bc, pcs;
        logic [3:0] aop;
        logic [1:0] srcb;
        logic [2:0] srca;
        logic       rr, rw;
        logic [1:0] szs, rdst;
        logic       hlt, ill;
    } exp_t;

    logic       Clk = 1'b0, Reset = 1'b0;
    logic [5:0] OPCODE = 6'h00;
    logic       PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, MDRWrite;
    logic [1:0] BranchCond, PCSource, ALUSrcB, SZS, RegDst;
    logic [3:0] ALUOp, State;
    logic [2:0] ALUSrcA;
    logic       RegRead, RegWrite, Halted, IllegalOp;

    multicycle_ctrl dut (
        .Clk(Clk), .Reset(Reset), .OPCODE(OPCODE),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .BranchCond(BranchCond), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegRead(RegRead),
        .RegWrite(RegWrite), .SZS(SZS), .RegDst(RegDst), .Halted(Halted),
        .IllegalOp(IllegalOp), .State(State)
    );

    always #5 Clk = ~Clk;

    exp_t  act, cur_exp;
    assign act = {PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, MDRWrite,
                  BranchCond, PCSource, ALUOp, ALUSrcB, ALUSrcA, RegRead,
                  RegWrite, SZS, RegDst, Halted, IllegalOp};

    int    checks = 0, failures = 0;
    logic  chk_en = 1'b0, chk_state = 1'b0;
    int    kk = 0;
    string tag = "idle";

    // Instruction length in cycles, FETCH included
    function automatic int instr_len(input logic [5:0] op);
        if (op[5:4] == 2'b00 || op[5:4] == 2'b01) return 4;
        case (op)
            6'h20: return 5;
            6'h21: return 4;
            6'h22, 6'h23, 6'h24: return 3;
            6'h25: return 4;
            6'h3F: return 24;
            default: return 3;
        endcase
    endfunction

    // Expected control word for cycle k of the instruction with opcode op
    function automatic exp_t model(input logic [5:0] op, input int k);
        exp_t e;
        e = '0;
        if (k == 0) begin
            e.irw = 1; e.srcb = 2'b01; e.pw = 1;
        end else if (k == 1) begin
            e.srcb = 2'b10;
        end else if (op[5:4] == 2'b00) begin
            if (k == 2) begin e.srca = 3'b001; e.aop = op[3:0]; end
            else begin e.rdst = 2'b01; e.rw = 1; end
        end else if (op[5:4] == 2'b01) begin
            if (k == 2) begin
                e.srca = 3'b100; e.srcb = 2'b10; e.aop = op[3:0]; e.szs = {1'b0, op[3]};
            end else e.rw = 1;
        end else if (op == 6'h20 || op == 6'h21) begin
            if (k == 4) begin e.m2r = 1; e.rw = 1; end
            else begin
                e.srca = 3'b100; e.srcb = 2'b10;
                if (k == 3) begin
                    if (op == 6'h20) e.mdrw = 1;
                    else e.mw = 1;
                end
            end
        end else if (op == 6'h22 || op == 6'h23) begin
            e.srca = 3'b001; e.aop = 4'h1; e.bc = {1'b0, op[0]}; e.pwc = 1; e.pcs = 2'b01;
        end else if (op == 6'h24) begin
            e.pcs = 2'b10; e.pw = 1;
        end else if (op == 6'h25) begin
            if (k == 2) e.aop = 4'hF;
            else begin e.rdst = 2'b10; e.rw = 1; e.pcs = 2'b10; e.pw = 1; end
        end else if (op == 6'h3F) begin
            e.hlt = 1;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            checks++;
            if (act !== cur_exp || (chk_state && State !== 4'h0)) begin
                failures++;
                $display("FAIL %s cyc%0d ctrl act=%h exp=%h State=%h", tag, kk, act, cur_exp, State);
            end
            checks++;
            if ($countones({IRWrite, RegWrite, MemWrite, MDRWrite}) > 1) begin
                failures++;
                $display("FAIL %s cyc%0d strobes irw=%b rw=%b mw=%b mdrw=%b exp at most one",
                         tag, kk, IRWrite, RegWrite, MemWrite, MDRWrite);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic run_n(input logic [5:0] op, input string name, input int n);
        OPCODE = op;
        tag = name;
        for (int k = 0; k < n; k++) begin
            kk = k;
            cur_exp = model(op, k);
            chk_state = (k == 0);
            chk_en = 1'b1;
            @(posedge Clk); #1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input string name);
        run_n(op, name, instr_len(op));
    endtask

    task automatic reset_pulse();
        Reset = 1'b0;
        tag = "reset";
        kk = 0;
        cur_exp = '0;
        chk_state = 1'b1;
        chk_en = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b1;
    endtask

    initial begin
        // Model pins from hand-derived values
        lit("pin_jal_aluop", {28'h0, model(6'h25, 2).aop}, 32'hF);
        lit("pin_beq_bc", {30'h0, model(6'h22, 2).bc}, 32'h0);
        lit("pin_bne_bc", {30'h0, model(6'h23, 2).bc}, 32'h1);
        lit("pin_lw_mdrw", {31'h0, model(6'h20, 3).mdrw}, 32'h1);
        lit("pin_lw_m2r", {30'h0, model(6'h20, 4).m2r, model(6'h20, 4).rw}, 32'h3);
        lit("pin_r_rdst", {30'h0, model(6'h00, 3).rdst}, 32'h1);
        lit("pin_len_lw", instr_len(6'h20), 32'd5);
        lit("pin_len_ill", instr_len(6'h3E), 32'd3);

        @(posedge Clk); #1;
        lit("reset_state", {28'h0, State}, 32'h0);
        lit("reset_irwrite", {31'h0, IRWrite}, 32'h0);
        reset_pulse();

        do_instr(6'h00, "r_add");
        do_instr(6'h0A, "r_op_a");
        do_instr(6'h10, "i_sext");
        do_instr(6'h19, "i_zext");
        do_instr(6'h20, "lw");
        do_instr(6'h21, "sw");
        do_instr(6'h22, "beq");
        do_instr(6'h23, "bne");
        do_instr(6'h24, "j");
        do_instr(6'h25, "jal");
        do_instr(6'h3E, "ill_3e");
        do_instr(6'h00, "r_after_ill");
        do_instr(6'h26, "ill_26");
        do_instr(6'h30, "ill_30");

        // Abandon a SW in MEM_WR with an asynchronous reset
        OPCODE = 6'h21;
        tag = "sw_abort";
        for (int k = 0; k < 3; k++) begin
            kk = k; cur_exp = model(6'h21, k); chk_state = (k == 0); chk_en = 1'b1;
            @(posedge Clk); #1;
        end
        kk = 3; cur_exp = model(6'h21, 3); chk_state = 1'b0;
        @(negedge Clk); #2;
        Reset = 1'b0;
        #1;
        lit("abort_memwrite", {31'h0, MemWrite}, 32'h0);
        lit("abort_state", {28'h0, State}, 32'h0);
        lit("abort_alusrca", {29'h0, ALUSrcA}, 32'h0);
        tag = "abort_rst"; cur_exp = '0; chk_state = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        do_instr(6'h20, "lw_after_abort");

        run_n(6'h3F, "halt", 24);
        lit("halt_held", {31'h0, Halted}, 32'h1);
        lit("halt_nowrite", {28'h0, RegWrite, MemWrite, PCWrite, IRWrite}, 32'h0);
        reset_pulse();
        do_instr(6'h0A, "r_after_halt");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
